program_counter_ras: RTL and testbench
======================================

Name: program_counter_ras

Overview:
Parametrised next-generation fetch program counter for the 16-bit pipelined RISC core. Drives the instruction-memory address and supports sequential increment, stall/hold, branch/jump load, and subroutine call/return. Call/return use an internal circular return-address stack (RAS) with sticky overflow/underflow flags. Sits in the IF stage and replaces the plain up-counter PC; branch/jump/call/ret requests come from the decode/execute control logic.

Parameters:
ADDR_W, 13, width of instruction-memory address and all address ports
RAS_DEPTH, 4, number of return-address stack entries (power of two, ≥2)
RESET_ADDR, 0, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
stall  input  1  hold PC (pipeline stall)
load_enable  input  1  branch/jump: load PC_load_addr
PC_load_addr  input  ADDR_W  target for load_enable/call; fallback target for ret on empty RAS
call  input  1  jump to PC_load_addr, push instr_mem_addr+1
ret  input  1  pop RAS top into PC
flag_clr  input  1  synchronous clear of sticky flags
instr_mem_addr  output  ADDR_W  current fetch address (registered)
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries
ras_empty  output  1  ras_count==0 (combinational from count)
ras_full  output  1  ras_count==RAS_DEPTH
ras_overflow  output  1  sticky: push attempted while full
ras_underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (reset==0, async, any time incl. mid-operation): instr_mem_addr=RESET_ADDR, ras_count=0, write pointer=0, ras_overflow=0, ras_underflow=0; ras_empty=1, ras_full=0. RAS storage contents need not be cleared.
- All updates on rising clk; one-cycle latency: request sampled at edge N, instr_mem_addr reflects it after edge N.
- Priority per cycle (highest first): ret, call, load_enable, stall, increment.
  - ret, RAS non-empty: PC <= entry[ptr-1 mod DEPTH]; ptr <= ptr-1; count <= count-1.
  - ret, RAS empty: PC <= PC_load_addr; ras_underflow <= 1; ptr/count unchanged.
  - call (ret=0): PC <= PC_load_addr; entry[ptr] <= instr_mem_addr+1 (mod 2^ADDR_W); ptr <= ptr+1 mod DEPTH.
    - count<DEPTH: count+1.
    - count==DEPTH: count stays; the oldest entry is overwritten (circular); ras_overflow <= 1.
  - load_enable (ret=call=0): PC <= PC_load_addr; RAS untouched.
  - stall (no redirect): PC holds. Control redirects override stall.
  - otherwise: PC <= PC+1, wrapping from 2^ADDR_W-1 to 0 with no flag.
- call and ret together: ret executes, call is ignored (no push).
- flag_clr: clears both sticky flags at the edge. If a new overflow/underflow event occurs in the same cycle, the set wins.
- Sticky flags do not affect PC/RAS operation.
- No combinational path from inputs to instr_mem_addr.

Test Plan:
- Reset/increment: release reset, no requests, 4 cycles -> instr_mem_addr 0,1,2,3,4; assert reset mid-count at 0x00A -> immediately 0x000, ras_count=0.
- Stall/branch/wrap: PC=0x005, stall 3 cycles -> holds 0x005; stall+load_enable to 0x1FFF -> 0x1FFF; next cycle -> 0x0000.
- Nested call/ret: at PC=0x010 call 0x100, at 0x102 call 0x200, then ret, ret -> PC 0x100, 0x101, 0x102, 0x200, 0x103, 0x011; ras_count 1,2,1,0; flags 0.
- Overflow: 5 calls from PCs 0x000,0x101,0x201,0x301,0x401 -> ras_full=1, ras_overflow=1, ras_count=4; 4 rets return 0x502? no: return 0x402,0x302,0x202,0x102; entry 0x001 is lost.
- Underflow/fallback: RAS empty, ret with PC_load_addr=0x0AB -> PC=0x0AB, ras_underflow=1, ras_count=0; flag_clr -> flag 0. flag_clr with a same-cycle empty ret -> flag remains 1.
- Simultaneous call+ret with one entry 0x050: -> PC=0x050, ras_count=0, no push.

Source files
------------

// File: rtl/program_counter_ras.sv
// Fetch program counter with a circular return-address stack.
// The PC advances sequentially, holds on stall, and is redirected by branch/jump
// loads and by subroutine call/return. A full stack overwrites its oldest entry
// on push, and an empty stack makes a return fall back to PC_load_addr. Two
// sticky flags record those events until flag_clr clears them.
module program_counter_ras #(
  parameter int ADDR_W     = 13,
  parameter int RAS_DEPTH  = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           load_enable,
  input  logic [ADDR_W-1:0]              PC_load_addr,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           flag_clr,
  output logic [ADDR_W-1:0]              instr_mem_addr,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  // Stack storage is never reset; the count alone defines which entries are valid.
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;
  logic              do_pop;
  logic              pop_fail;
  logic              do_push;
  logic              push_ovf;

  // Request decode: a return always wins over a call issued in the same cycle.
  always_comb begin
    ras_empty = (ras_count == '0);
    ras_full  = (ras_count == CNT_W'(RAS_DEPTH));
    top_ptr   = wr_ptr - 1'b1;
    pc_inc    = instr_mem_addr + 1'b1;
    do_pop    = ret && !ras_empty;
    pop_fail  = ret && ras_empty;
    do_push   = call && !ret;
    push_ovf  = do_push && ras_full;
  end

  // Next-PC selection by priority: ret, call, load, stall, sequential increment.
  always_comb begin
    pc_next = pc_inc;
    if (ret) begin
      pc_next = do_pop ? ras_mem[top_ptr] : PC_load_addr;
    end else if (call || load_enable) begin
      pc_next = PC_load_addr;
    end else if (stall) begin
      pc_next = instr_mem_addr;
    end
  end

  // PC register, stack pointer and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_mem_addr <= ADDR_W'(RESET_ADDR);
      wr_ptr         <= '0;
      ras_count      <= '0;
    end else begin
      instr_mem_addr <= pc_next;
      if (do_pop) begin
        wr_ptr    <= top_ptr;
        ras_count <= ras_count - 1'b1;
      end else if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!ras_full) ras_count <= ras_count + 1'b1;
      end
    end
  end

  // Sticky event flags; a new event in the same cycle beats flag_clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (push_ovf)      ras_overflow <= 1'b1;
      else if (flag_clr) ras_overflow <= 1'b0;
      if (pop_fail)      ras_underflow <= 1'b1;
      else if (flag_clr) ras_underflow <= 1'b0;
    end
  end

  // Return-address write; a push while full lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (do_push) ras_mem[wr_ptr] <= pc_inc;
  end

endmodule

// File: tb/tb_program_counter_ras.sv
// Testbench for program_counter_ras: directed scenarios plus a randomized run
// checked against a queue-based stack model.
module tb_program_counter_ras;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int MASK   = (1 << ADDR_W) - 1;

  logic              clk = 0;
  logic              reset = 0;
  logic              stall = 0;
  logic              load_enable = 0;
  logic [ADDR_W-1:0] PC_load_addr = '0;
  logic              call = 0;
  logic              ret = 0;
  logic              flag_clr = 0;
  logic [ADDR_W-1:0] instr_mem_addr;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: PC as an integer, the stack as a queue (back = top).
  int m_pc;
  int m_q[$];
  bit m_ovf;
  bit m_unf;

  program_counter_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(DEPTH), .RESET_ADDR(0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .load_enable(load_enable),
    .PC_load_addr(PC_load_addr), .call(call), .ret(ret), .flag_clr(flag_clr),
    .instr_mem_addr(instr_mem_addr), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 0;
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic apply_reset();
    reset = 0;
    {stall, load_enable, call, ret, flag_clr} = '0;
    PC_load_addr = '0;
    #3;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  // Drive one cycle of requests, advance the model at the edge, settle #1 after.
  task automatic cycle(input bit r, input bit c, input bit l, input bit s,
                       input bit fc, input int addr);
    bit ovf_evt, unf_evt;
    ret = r; call = c; load_enable = l; stall = s; flag_clr = fc;
    PC_load_addr = addr[ADDR_W-1:0];
    @(posedge clk);
    ovf_evt = 0;
    unf_evt = 0;
    if (r) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin m_pc = addr & MASK; unf_evt = 1; end
    end else if (c) begin
      if (m_q.size() == DEPTH) begin void'(m_q.pop_front()); ovf_evt = 1; end
      m_q.push_back((m_pc + 1) & MASK);
      m_pc = addr & MASK;
    end else if (l) begin
      m_pc = addr & MASK;
    end else if (!s) begin
      m_pc = (m_pc + 1) & MASK;
    end
    if (fc) begin m_ovf = 0; m_unf = 0; end
    if (ovf_evt) m_ovf = 1;
    if (unf_evt) m_unf = 1;
    #1;
    {ret, call, load_enable, stall, flag_clr} = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (instr_mem_addr !== 13'h000) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", instr_mem_addr); end
    n_checks++; if (ras_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", ras_count); end
    n_checks++; if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000)
      begin n_fail++; $display("FAIL reset_flags: got %b expected 1000", {ras_empty, ras_full, ras_overflow, ras_underflow}); end
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      n_checks++; if (instr_mem_addr !== 13'(i)) begin n_fail++; $display("FAIL inc_pc: got %0h expected %0h", instr_mem_addr, i); end
    end
    // Push one entry so the async reset visibly clears the count too.
    cycle(0, 1, 0, 0, 0, 'h008);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (instr_mem_addr !== 13'h00A || ras_count !== 3'd1)
      begin n_fail++; $display("FAIL pre_async: got pc %0h cnt %0d expected pc a cnt 1", instr_mem_addr, ras_count); end
    #2;
    reset = 0;
    #1;
    n_checks++; if (instr_mem_addr !== 13'h000 || ras_count !== 3'd0 || ras_empty !== 1'b1)
      begin n_fail++; $display("FAIL async_reset: got pc %0h cnt %0d empty %b expected pc 0 cnt 0 empty 1", instr_mem_addr, ras_count, ras_empty); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic test_stall_branch_wrap();
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      n_checks++; if (instr_mem_addr !== 13'h005) begin n_fail++; $display("FAIL stall_hold: got %0h expected 5", instr_mem_addr); end
    end
    cycle(0, 0, 1, 1, 0, 'h1FFF);
    n_checks++; if (instr_mem_addr !== 13'h1FFF) begin n_fail++; $display("FAIL load_over_stall: got %0h expected 1fff", instr_mem_addr); end
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (instr_mem_addr !== 13'h0000) begin n_fail++; $display("FAIL wrap: got %0h expected 0", instr_mem_addr); end
    n_checks++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin n_fail++; $display("FAIL wrap_flags: got %b%b expected 00", ras_overflow, ras_underflow); end
  endtask

  task automatic test_nested_call();
    int exp_pc[6]  = '{'h100, 'h101, 'h102, 'h200, 'h103, 'h011};
    int exp_cnt[6] = '{1, 1, 1, 2, 1, 0};
    apply_reset();
    cycle(0, 0, 1, 0, 0, 'h010);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: cycle(0, 1, 0, 0, 0, 'h100);
        3: cycle(0, 1, 0, 0, 0, 'h200);
        4, 5: cycle(1, 0, 0, 0, 0, 'h7FF);
        default: cycle(0, 0, 0, 0, 0, 0);
      endcase
      n_checks++; if (instr_mem_addr !== 13'(exp_pc[i]) || ras_count !== 3'(exp_cnt[i]))
        begin n_fail++; $display("FAIL nested_%0d: got pc %0h cnt %0d expected pc %0h cnt %0d", i, instr_mem_addr, ras_count, exp_pc[i], exp_cnt[i]); end
    end
    n_checks++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin n_fail++; $display("FAIL nested_flags: got %b%b expected 00", ras_overflow, ras_underflow); end
  endtask

  task automatic test_overflow();
    int exp_ret[4] = '{'h402, 'h302, 'h202, 'h102};
    apply_reset();
    for (int k = 1; k <= 5; k++) begin
      cycle(0, 1, 0, 0, 0, k * 'h100);
      if (k == 4) begin
        n_checks++; if (ras_full !== 1'b1 || ras_overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got full %b ovf %b expected 1 0", ras_full, ras_overflow); end
      end
      if (k < 5) cycle(0, 0, 0, 0, 0, 0);
    end
    n_checks++; if (ras_full !== 1'b1 || ras_overflow !== 1'b1 || ras_count !== 3'd4)
      begin n_fail++; $display("FAIL overflow: got full %b ovf %b cnt %0d expected 1 1 4", ras_full, ras_overflow, ras_count); end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 0, 'h1234);
      n_checks++; if (instr_mem_addr !== 13'(exp_ret[i]) || ras_count !== 3'(3 - i))
        begin n_fail++; $display("FAIL ovf_ret_%0d: got pc %0h cnt %0d expected pc %0h cnt %0d", i, instr_mem_addr, ras_count, exp_ret[i], 3 - i); end
    end
    n_checks++; if (ras_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ras_overflow); end
  endtask

  task automatic test_underflow();
    apply_reset();
    cycle(1, 0, 0, 0, 0, 'h0AB);
    n_checks++; if (instr_mem_addr !== 13'h0AB || ras_underflow !== 1'b1 || ras_count !== 3'd0)
      begin n_fail++; $display("FAIL underflow: got pc %0h unf %b cnt %0d expected ab 1 0", instr_mem_addr, ras_underflow, ras_count); end
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++; if (ras_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky: got %b expected 1", ras_underflow); end
    cycle(0, 0, 0, 0, 1, 0);
    n_checks++; if (ras_underflow !== 1'b0) begin n_fail++; $display("FAIL flag_clr: got %b expected 0", ras_underflow); end
    cycle(1, 0, 0, 0, 1, 'h055);
    n_checks++; if (ras_underflow !== 1'b1 || instr_mem_addr !== 13'h055)
      begin n_fail++; $display("FAIL set_beats_clr: got unf %b pc %0h expected 1 55", ras_underflow, instr_mem_addr); end
  endtask

  task automatic test_call_ret_same();
    apply_reset();
    cycle(0, 0, 1, 0, 0, 'h04F);
    cycle(0, 1, 0, 0, 0, 'h300);
    cycle(1, 1, 0, 0, 0, 'h123);
    n_checks++; if (instr_mem_addr !== 13'h050 || ras_count !== 3'd0 || ras_empty !== 1'b1)
      begin n_fail++; $display("FAIL call_ret: got pc %0h cnt %0d expected 50 0", instr_mem_addr, ras_count); end
    cycle(1, 0, 0, 0, 0, 'h0CD);
    n_checks++; if (instr_mem_addr !== 13'h0CD || ras_underflow !== 1'b1)
      begin n_fail++; $display("FAIL call_ret_nopush: got pc %0h unf %b expected cd 1", instr_mem_addr, ras_underflow); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 18,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 6, int'($urandom_range(0, MASK)));
      n_checks++; if (instr_mem_addr !== 13'(m_pc)) begin n_fail++; $display("FAIL rnd_pc cyc %0d: got %0h expected %0h", i, instr_mem_addr, m_pc); end
      n_checks++; if (ras_count !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_cnt cyc %0d: got %0d expected %0d", i, ras_count, m_q.size()); end
      n_checks++; if (ras_empty !== (m_q.size() == 0) || ras_full !== (m_q.size() == DEPTH))
        begin n_fail++; $display("FAIL rnd_ef cyc %0d: got %b%b expected %b%b", i, ras_empty, ras_full, m_q.size() == 0, m_q.size() == DEPTH); end
      n_checks++; if (ras_overflow !== m_ovf || ras_underflow !== m_unf)
        begin n_fail++; $display("FAIL rnd_flags cyc %0d: got %b%b expected %b%b", i, ras_overflow, ras_underflow, m_ovf, m_unf); end
    end
  endtask

  initial begin
    test_reset();
    test_stall_branch_wrap();
    test_nested_call();
    test_overflow();
    test_underflow();
    test_call_ret_same();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
